// File: rtl/data_mem_responder_pkg.sv
// mem_pkg: shared state encoding, default sizing and address check for the data memory responder
package mem_pkg;
  localparam int DEPTH_WORDS_DEF = 256;
  localparam int WAIT_CYCLES_DEF = 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic addr_ok(input logic [31:0] a, input logic [31:0] depth);
    return a[1:0] == 2'b00 && {2'b00, a[31:2]} < depth;
  endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// mem_if: CPU-side request/response bus of the data memory responder
interface mem_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Addres;
  logic [31:0] WriteData;
  logic [31:0] readData;
  logic        MemReady;
  logic        MemErr;
  modport master(output MemReq, MemWrite, Addres, WriteData, input readData, MemReady, MemErr);
  modport slave(input MemReq, MemWrite, Addres, WriteData, output readData, MemReady, MemErr);
endinterface

// File: rtl/data_mem_responder_wait_counter.sv
// Wait_Counter: loadable down-counter timing the wait states, flags zero
module Wait_Counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);
  logic [WIDTH-1:0] cnt;
  // Load on entry to WAIT, count down while waiting.
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with wait states and a one-cycle ready/error response
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input logic   clk,
  input logic   rst,
  mem_if.slave  bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  state_t state, state_nx;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic wr_q, err_q;
  logic [31:0] a_addr, a_wdata;
  logic [AW-1:0] a_idx;
  logic a_wr, a_ok, acc, cnt_load, cnt_dec, cnt_zero;
  logic [31:0] mem [DEPTH_WORDS];
  Wait_Counter #(.WIDTH(CW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(cnt_load),
    .dec(cnt_dec),
    .load_val(CW'(WAIT_CYCLES - 1)),
    .zero(cnt_zero)
  );
  // With no wait states the access happens on the accepting edge, straight from the bus.
  assign a_addr  = state == IDLE ? bus.Addres : addr_q;
  assign a_wdata = state == IDLE ? bus.WriteData : wdata_q;
  assign a_wr    = state == IDLE ? bus.MemWrite : wr_q;
  assign a_ok    = addr_ok(a_addr, 32'(DEPTH_WORDS));
  assign a_idx   = a_addr[AW+1:2];
  // Next state, counter control and access strobe.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    acc      = 1'b0;
    case (state)
      IDLE: if (bus.MemReq) begin
        state_nx = WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt_load = WAIT_CYCLES != 0;
        acc      = WAIT_CYCLES == 0;
      end
      WAIT: begin
        state_nx = cnt_zero ? RESP : WAIT;
        cnt_dec  = !cnt_zero;
        acc      = cnt_zero;
      end
      default: state_nx = IDLE;
    endcase
  end
  // State, request latch and response registers; reset aborts any pending access.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.MemReq) begin
        addr_q  <= bus.Addres;
        wdata_q <= bus.WriteData;
        wr_q    <= bus.MemWrite;
      end
      if (acc) begin
        err_q <= !a_ok;
        if (!a_wr) rdata_q <= a_ok ? mem[a_idx] : '0;
      end
    end
  // Storage has no reset so its contents survive rst.
  always_ff @(posedge clk)
    if (acc && rst && a_wr && a_ok) mem[a_idx] <= a_wdata;
  assign bus.readData = rdata_q;
  assign bus.MemReady = state == RESP;
  assign bus.MemErr   = state == RESP && err_q;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before each access (0 allowed).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MemReq  input  1  request strobe from CPU.
REQ-006 SHALL have port MemWrite  input  1  1 = write, 0 = read; sampled with MemReq.
REQ-007 SHALL have port Addres  input  32  byte address from CPU.
REQ-008 SHALL have port WriteData  input  32  store data.
REQ-009 SHALL have port readData  output  32  load data returned to CPU.
REQ-010 SHALL have port MemReady  output  1  one-cycle completion pulse.
REQ-011 SHALL have port MemErr  output  1  qualifies MemReady; access rejected.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 IDLE: MemReq=1 at a rising edge SHALL latch Addres, WriteData, MemWrite and go to WAIT (WAIT_CYCLES>0) or perform the access and go to RESP (WAIT_CYCLES=0).
REQ-014 IDLE with MemReq=0 SHALL remain in IDLE.
REQ-015 WAIT SHALL load a counter with WAIT_CYCLES-1 on entry and decrement each edge; at count 0 the next edge SHALL perform the access and enter RESP.
REQ-016 Latency: MemReady SHALL be high during exactly one cycle, beginning WAIT_CYCLES+1 edges after the accepting edge.
REQ-017 RESP SHALL drive MemReady=1 for that one cycle, then return to IDLE unconditionally.
REQ-018 Inputs SHALL be ignored in WAIT and RESP; only latched values are used.
REQ-019 A request held high through RESP SHALL be re-accepted only in IDLE, so the minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-020 Word index SHALL be latched Addres[31:2]; an access is valid only if Addres[1:0]=0 and the index < DEPTH_WORDS.
REQ-021 A valid write SHALL update the word on the access edge; readData SHALL then be unchanged.
REQ-022 A valid read SHALL load readData with the stored word on the access edge; readData SHALL hold until the next completed read.
REQ-023 An invalid access SHALL not modify memory, SHALL set readData to 0 if it was a read, and SHALL assert MemErr together with MemReady.
REQ-024 MemErr SHALL be 0 whenever MemReady is 0.

Reset
REQ-025 rst low SHALL immediately force state IDLE, counter 0, MemReady=0, MemErr=0 and readData=0.
REQ-026 Reset SHALL NOT clear memory contents.
REQ-027 Reset asserted in WAIT SHALL abort the pending access; no write occurs and no MemReady pulse is generated.
REQ-028 On the first edge after rst rises, MemReq=1 SHALL be accepted normally.

Structure
REQ-029 Package mem_pkg SHALL hold the state enum and the defaults DEPTH_WORDS_DEF=256 and WAIT_CYCLES_DEF=1.
REQ-030 The wait counter SHALL be a sub-module Wait_Counter with load, decrement and zero-flag outputs; the storage array and FSM stay in the top module.

Verification
REQ-031 W=1: write 0xDEADBEEF to 0x10, then read 0x10 -> each MemReady arrives 2 edges after accept; read returns 0xDEADBEEF; MemErr=0.
REQ-032 W=0: read 0x00 after writing 0x12345678 -> MemReady on the edge after accept; readData=0x12345678.
REQ-033 Write to 0x13 (misaligned) and write to 0x400 (DEPTH 256) -> MemReady+MemErr both times; a later read of 0x10 shows the prior value unchanged.
REQ-034 Hold MemReq=1 continuously with W=1 -> MemReady pulses every 3 cycles; no extra accepts.
REQ-035 Assert rst low during WAIT of a write of 0xA5A5A5A5 to 0x20 -> outputs 0 immediately; no MemReady; a later read of 0x20 returns the old value.
REQ-036 Change Addres/WriteData during WAIT -> the access uses the originally latched values.
